// File: rtl/led_beep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_beep_pkg
// Purpose  : Shared types and widths for the LED pattern / buzzer block.
// Revision : 1.0 - initial release
// ============================================================================
package led_beep_pkg;

  localparam int PERIOD_W = 16;  // config period / tick-length fields
  localparam int BCNT_W   = 4;   // burst count field

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    BEEP_IDLE = 2'd0,
    BEEP_ON   = 2'd1,
    BEEP_GAP  = 2'd2
  } beep_state_e;

  // A zero length would never match a counter compare, so it behaves as 1.
  function automatic logic [PERIOD_W-1:0] fix_zero(input logic [PERIOD_W-1:0] v);
    return (v == '0) ? PERIOD_W'(1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_chan.sv
`default_nettype none
// ============================================================================
// Module   : led_chan
// Purpose  : One LED channel: off / on / blink / breathe, producing "lit".
// Revision : 1.0 - initial release
// ============================================================================
module led_chan
  import led_beep_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  led_mode_e           cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                lit
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  led_mode_e           mode_q,   mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q,    cnt_d;
  logic                phase_q,  phase_d;
  logic [PWM_BITS-1:0] duty_q,   duty_d;
  logic                dn_q,     dn_d;

  // Next-state: config load has priority, otherwise advance on time-base ticks.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    duty_d   = duty_q;
    dn_d     = dn_q;
    if (we) begin
      mode_d   = cfg_mode;
      period_d = fix_zero(cfg_period);
      cnt_d    = '0;
      phase_d  = 1'b1;
      duty_d   = '0;
      dn_d     = 1'b0;
    end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_BREATHE)) begin
      if (cnt_q == period_q - PERIOD_W'(1)) begin
        cnt_d = '0;
        if (mode_q == MODE_BLINK) begin
          phase_d = ~phase_q;
        end else if (!dn_q) begin
          // Turn around as the endpoint is reached so it is shown for one step only.
          duty_d = duty_q + PWM_BITS'(1);
          if (duty_q == DUTY_MAX - PWM_BITS'(1)) dn_d = 1'b1;
        end else begin
          duty_d = duty_q - PWM_BITS'(1);
          if (duty_q == PWM_BITS'(1)) dn_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_OFF;
      period_q <= PERIOD_W'(1);
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      duty_q   <= '0;
      dn_q     <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      duty_q   <= duty_d;
      dn_q     <= dn_d;
    end
  end

  // Lit decode; breathe compares the shared PWM ramp against duty.
  always_comb begin
    lit = 1'b0;
    case (mode_q)
      MODE_OFF:     lit = 1'b0;
      MODE_ON:      lit = 1'b1;
      MODE_BLINK:   lit = phase_q;
      MODE_BREATHE: lit = (pwm_cnt < duty_q);
      default:      lit = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/led_beep_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_beep_seq
// Purpose  : Multi-channel LED pattern generator with burst buzzer driver.
// Revision : 1.0 - initial release
// ============================================================================
module led_beep_seq
  import led_beep_pkg::*;
#(
  parameter int N_LED          = 4,
  parameter int TICK_DIV       = 50_000,
  parameter int PWM_BITS       = 8,
  parameter int BEEP_HALF      = 10_000,
  parameter int LED_ACTIVE_LOW = 1,
  localparam int CH_W          = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                beep_start,
  input  logic                beep_stop,
  input  logic [BCNT_W-1:0]   beep_count,
  input  logic [PERIOD_W-1:0] beep_on_ticks,
  input  logic [PERIOD_W-1:0] beep_off_ticks,
  output logic [N_LED-1:0]    led,
  output logic                beep,
  output logic                beep_busy
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int TONE_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam logic [N_LED-1:0] LED_UNLIT = (LED_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q,   pwm_d;
  logic [N_LED-1:0]    led_q,   led_d;
  logic                tick;
  logic [N_LED-1:0]    chan_we;
  logic [N_LED-1:0]    chan_lit;

  beep_state_e         state_q, state_d;
  logic [BCNT_W-1:0]   rem_q,   rem_d;
  logic [PERIOD_W-1:0] on_q,    on_d;
  logic [PERIOD_W-1:0] off_q,   off_d;
  logic [PERIOD_W-1:0] tcnt_q,  tcnt_d;
  logic [TONE_W-1:0]   tone_q,  tone_d;
  logic                beep_q,  beep_d;
  logic                busy_q,  busy_d;

  assign tick = (presc_q == PRESC_W'(TICK_DIV - 1));

  // Shared time base, free-running PWM ramp and pin polarity.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    pwm_d   = pwm_q + PWM_BITS'(1);
    led_d   = (LED_ACTIVE_LOW != 0) ? ~chan_lit : chan_lit;
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_chan
    // Only an in-range index can ever match, so out-of-range writes drop out.
    assign chan_we[i] = cfg_we && (cfg_ch == CH_W'(i));

    led_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .we         (chan_we[i]),
      .cfg_mode   (led_mode_e'(cfg_mode)),
      .cfg_period (cfg_period),
      .tick       (tick),
      .pwm_cnt    (pwm_q),
      .lit        (chan_lit[i])
    );
  end

  // Beep sequencer next-state; stop overrides everything including a start.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    on_d    = on_q;
    off_d   = off_q;
    tcnt_d  = tcnt_q;
    tone_d  = tone_q;
    beep_d  = beep_q;
    busy_d  = busy_q;
    if (beep_stop) begin
      state_d = BEEP_IDLE;
      beep_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        BEEP_IDLE: begin
          beep_d = 1'b0;
          busy_d = 1'b0;
          if (beep_start && (beep_count != '0)) begin
            state_d = BEEP_ON;
            rem_d   = beep_count;
            on_d    = fix_zero(beep_on_ticks);
            off_d   = fix_zero(beep_off_ticks);
            tcnt_d  = '0;
            tone_d  = '0;
            beep_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
        BEEP_ON: begin
          if (tone_q == TONE_W'(BEEP_HALF - 1)) begin
            tone_d = '0;
            beep_d = ~beep_q;
          end else begin
            tone_d = tone_q + TONE_W'(1);
          end
          if (tick) begin
            if (tcnt_q == on_q - PERIOD_W'(1)) begin
              tcnt_d = '0;
              tone_d = '0;
              rem_d  = rem_q - BCNT_W'(1);
              beep_d = 1'b0;
              if (rem_q == BCNT_W'(1)) begin
                state_d = BEEP_IDLE;
                busy_d  = 1'b0;
              end else begin
                state_d = BEEP_GAP;
              end
            end else begin
              tcnt_d = tcnt_q + PERIOD_W'(1);
            end
          end
        end
        BEEP_GAP: begin
          beep_d = 1'b0;
          if (tick) begin
            if (tcnt_q == off_q - PERIOD_W'(1)) begin
              tcnt_d  = '0;
              tone_d  = '0;
              state_d = BEEP_ON;
              beep_d  = 1'b1;
            end else begin
              tcnt_d = tcnt_q + PERIOD_W'(1);
            end
          end
        end
        default: begin
          state_d = BEEP_IDLE;
          beep_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // All top-level state, including the registered pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      led_q   <= LED_UNLIT;
      state_q <= BEEP_IDLE;
      rem_q   <= '0;
      on_q    <= PERIOD_W'(1);
      off_q   <= PERIOD_W'(1);
      tcnt_q  <= '0;
      tone_q  <= '0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      on_q    <= on_d;
      off_q   <= off_d;
      tcnt_q  <= tcnt_d;
      tone_q  <= tone_d;
      beep_q  <= beep_d;
      busy_q  <= busy_d;
    end
  end

  assign led       = led_q;
  assign beep      = beep_q;
  assign beep_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_led_beep_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_beep_seq
// Purpose  : Self-checking bench for led_beep_seq (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_beep_seq;

  localparam int N_LED     = 4;
  localparam int TICK_DIV  = 4;
  localparam int PWM_BITS  = 4;
  localparam int BEEP_HALF = 2;
  localparam int PWM_LEN   = 1 << PWM_BITS;
  localparam int TRI_LEN   = 2 * (PWM_LEN - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic        beep_start = 1'b0;
  logic        beep_stop = 1'b0;
  logic [3:0]  beep_count = '0;
  logic [15:0] beep_on_ticks = '0;
  logic [15:0] beep_off_ticks = '0;
  logic [3:0]  led;
  logic        beep;
  logic        beep_busy;

  led_beep_seq #(
    .N_LED          (N_LED),
    .TICK_DIV       (TICK_DIV),
    .PWM_BITS       (PWM_BITS),
    .BEEP_HALF      (BEEP_HALF),
    .LED_ACTIVE_LOW (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_mode       (cfg_mode),
    .cfg_period     (cfg_period),
    .beep_start     (beep_start),
    .beep_stop      (beep_stop),
    .beep_count     (beep_count),
    .beep_on_ticks  (beep_on_ticks),
    .beep_off_ticks (beep_off_ticks),
    .led            (led),
    .beep           (beep),
    .beep_busy      (beep_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (absolute-time arithmetic) -------------
  // e = number of clock edges since reset release. Ticks land on edges that
  // are multiples of TICK_DIV; the PWM ramp after edge s is s mod PWM_LEN.
  int e = 0;
  int mm[4];             // mode per channel
  int mp[4];             // period per channel
  int mw[4];             // edge of the last write per channel
  int bs[16], be[16];    // tone-on intervals [bs, be) in edges
  int nb = 0;
  int b_start = 0, b_end = 0;
  logic [3:0] exp_led = 4'hF;
  logic       exp_beep = 1'b0;
  logic       exp_busy = 1'b0;

  function automatic bit model_lit(input int i, input int s);
    int pe, k, st, d;
    pe = (mp[i] == 0) ? 1 : mp[i];
    k  = s / TICK_DIV - mw[i] / TICK_DIV;   // ticks seen since the write
    case (mm[i])
      0: return 1'b0;
      1: return 1'b1;
      2: return ((k / pe) % 2) == 0;
      default: begin
        st = k / pe;
        d  = st % TRI_LEN;
        if (d > PWM_LEN - 1) d = TRI_LEN - d;
        return d > (s % PWM_LEN);
      end
    endcase
  endfunction

  // Edge of the n-th tick strictly after edge x.
  function automatic int next_tick(input int x, input int n);
    return (x / TICK_DIV + n) * TICK_DIV;
  endfunction

  always @(negedge rst) begin
    e = 0;
    for (int i = 0; i < 4; i++) begin
      mm[i] = 0; mp[i] = 0; mw[i] = 0;
    end
    nb = 0; b_start = 0; b_end = 0;
    exp_led = 4'hF; exp_beep = 1'b0; exp_busy = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      int  x, on_e, off_e;
      bit  busy_prev;
      e = e + 1;
      // Pins after this edge show channel state from the previous edge.
      for (int i = 0; i < 4; i++) exp_led[i] = ~model_lit(i, e - 1);
      if (cfg_we) begin
        mm[cfg_ch] = int'(cfg_mode);
        mp[cfg_ch] = int'(cfg_period);
        mw[cfg_ch] = e;
      end
      busy_prev = (b_start <= e - 1) && (e - 1 < b_end);
      if (beep_stop) begin
        if (busy_prev) b_end = e;
      end else if (beep_start && !busy_prev && beep_count != 0) begin
        on_e    = (beep_on_ticks == 0) ? 1 : int'(beep_on_ticks);
        off_e   = (beep_off_ticks == 0) ? 1 : int'(beep_off_ticks);
        x       = e;
        nb      = 0;
        b_start = e;
        for (int j = 0; j < int'(beep_count); j++) begin
          bs[nb] = x;
          be[nb] = next_tick(x, on_e);
          x      = be[nb];
          nb++;
          if (j < int'(beep_count) - 1) x = next_tick(x, off_e);
        end
        b_end = be[nb-1];
      end
      exp_busy = (b_start <= e) && (e < b_end);
      exp_beep = 1'b0;
      for (int j = 0; j < nb; j++)
        if (bs[j] <= e && e < be[j] && (((e - bs[j]) / BEEP_HALF) % 2) == 0)
          exp_beep = exp_busy;
    end
  end

  // Every cycle out of reset, pins are compared to the model.
  always @(negedge clk) begin
    if (rst) begin
      check("mon_led", 32'(led), 32'(exp_led));
      check("mon_beep", 32'(beep), 32'(exp_beep));
      check("mon_busy", 32'(beep_busy), 32'(exp_busy));
    end
  end

  // ---------------- helpers ------------------------------------------------
  task automatic cfg(input int ch, input int mode, input int per);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_period = 16'(per);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_beep(input int cnt, input int on, input int off);
    beep_start = 1'b1; beep_count = 4'(cnt);
    beep_on_ticks = 16'(on); beep_off_ticks = 16'(off);
    @(negedge clk);
    beep_start = 1'b0;
  endtask

  // Length of the current run of led[0], measured from a negedge.
  task automatic run_len(output int n);
    logic v;
    v = led[0];
    n = 0;
    while (led[0] == v && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [1:0] mode;
    logic       start;
    logic [3:0] cnt;
    logic [3:0] exp_led;
    logic       exp_busy;
  } vec_t;

  vec_t vt[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dur;
    vt[0] = '{1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 4'b1111, 1'b0};
    vt[1] = '{1'b1, 2'd2, 2'd1, 1'b0, 4'd0, 4'b1011, 1'b0};
    vt[2] = '{1'b1, 2'd0, 2'd1, 1'b0, 4'd0, 4'b1010, 1'b0};
    vt[3] = '{1'b1, 2'd2, 2'd0, 1'b0, 4'd0, 4'b1110, 1'b0};
    vt[4] = '{1'b1, 2'd3, 2'd1, 1'b0, 4'd0, 4'b0110, 1'b0};
    vt[5] = '{1'b1, 2'd0, 2'd0, 1'b0, 4'd0, 4'b0111, 1'b0};
    vt[6] = '{1'b1, 2'd3, 2'd0, 1'b0, 4'd0, 4'b1111, 1'b0};
    vt[7] = '{1'b0, 2'd0, 2'd0, 1'b1, 4'd0, 4'b1111, 1'b0};
    vt[8] = '{1'b1, 2'd1, 2'd1, 1'b0, 4'd0, 4'b1101, 1'b0};
    vt[9] = '{1'b1, 2'd1, 2'd0, 1'b0, 4'd0, 4'b1111, 1'b0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'hF);
    check("rst_beep", 32'(beep), 0);
    check("rst_busy", 32'(beep_busy), 0);
    rst = 1'b1;

    // Table: ON/OFF writes and a zero-count start, each seen 2 clocks later.
    for (int i = 0; i < 10; i++) begin
      cfg_we = vt[i].we; cfg_ch = vt[i].ch; cfg_mode = vt[i].mode; cfg_period = 16'd1;
      beep_start = vt[i].start; beep_count = vt[i].cnt;
      beep_on_ticks = 16'd1; beep_off_ticks = 16'd1;
      @(negedge clk);
      cfg_we = 1'b0; beep_start = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vt[i].exp_led));
      check($sformatf("vec%0d_busy", i), 32'(beep_busy), 32'(vt[i].exp_busy));
    end

    // Blink with a 3-tick half-period: 12-clock runs.
    cfg(0, 2, 3);
    @(negedge clk);
    run_len(n);
    run_len(n); check("blink3_hi_run", 32'(n), 12);
    run_len(n); check("blink3_lo_run", 32'(n), 12);

    // Period 0 behaves as 1: 4-clock runs.
    cfg(0, 2, 0);
    @(negedge clk);
    run_len(n);
    run_len(n); check("blink0_run_a", 32'(n), 4);
    run_len(n); check("blink0_run_b", 32'(n), 4);
    cfg(0, 0, 1);

    // Breathe for more than one full triangle.
    cfg(1, 3, 1);
    repeat (140) @(negedge clk);
    cfg(1, 0, 1);

    // Two bursts, on=2 ticks, off=1 tick.
    start_beep(2, 2, 1);
    check("burst_busy_up", 32'(beep_busy), 1);
    check("burst_beep_up", 32'(beep), 1);
    dur = 1;
    while (beep_busy && dur < 60) begin
      @(negedge clk);
      if (beep_busy) dur++;
    end
    check("burst_len_in_range", 32'(dur >= 17 && dur <= 20), 1);
    check("burst_beep_end", 32'(beep), 0);

    // Stop in the middle of a tone.
    start_beep(3, 3, 1);
    repeat (3) @(negedge clk);
    beep_stop = 1'b1;
    @(negedge clk);
    beep_stop = 1'b0;
    check("stop_beep", 32'(beep), 0);
    check("stop_busy", 32'(beep_busy), 0);

    // A second start while busy must not extend the sequence.
    start_beep(1, 2, 1);
    repeat (2) @(negedge clk);
    start_beep(3, 3, 3);
    repeat (10) @(negedge clk);
    check("no_restart", 32'(beep_busy), 0);

    // Asynchronous reset between edges while blinking and beeping.
    cfg(0, 2, 1);
    cfg(3, 1, 1);
    start_beep(3, 3, 2);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(beep_busy), 1);
    rst = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'hF);
    check("arst_beep", 32'(beep), 0);
    check("arst_busy", 32'(beep_busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_led", 32'(led), 32'hF);
    check("post_rst_busy", 32'(beep_busy), 0);

    // Random traffic against the model.
    repeat (3000) begin
      cfg_we         = ($urandom_range(0, 15) == 0);
      cfg_ch         = 2'($urandom_range(0, 3));
      cfg_mode       = 2'($urandom_range(0, 3));
      cfg_period     = 16'($urandom_range(0, 4));
      beep_start     = ($urandom_range(0, 19) == 0);
      beep_stop      = ($urandom_range(0, 59) == 0);
      beep_count     = 4'($urandom_range(0, 3));
      beep_on_ticks  = 16'($urandom_range(0, 3));
      beep_off_ticks = 16'($urandom_range(0, 3));
      @(negedge clk);
    end
    cfg_we = 1'b0; beep_start = 1'b0; beep_stop = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
